// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Owns the single instruction-RAM port and time-shares it between a host
// program loader and the pipeline IF stage. While a program image is being
// streamed in, the pipeline is held (cpu_run_o = 0, fetch_stall_o = 1) and
// the loader writes one 32-bit word per accepted beat at consecutive word
// addresses. After the last word there is a single DONE cycle, and then the
// pipeline is released into RUN, where fetches go straight through to the
// RAM's combinational read port.
//
// Ports
//   clk, rst            sole clock, synchronous active-high reset
//   load_start_i        start a load session (honoured in IDLE and RUN only)
//   load_base_addr_i    byte start address of the image, bits [1:0] ignored
//   load_count_i        number of words in the image, 1..DEPTH_WORDS
//   run_i               IDLE -> RUN without loading
//   load_valid_i/       loader word stream; a word is taken when
//   load_data_i/        load_valid_i & load_ready_o
//   load_ready_o
//   fetch_addr_i        IF-stage byte PC
//   fetch_instr_o       instruction to IF (NOP_INSTR unless running)
//   fetch_stall_o       IF must hold its PC
//   imem_addr_o         byte address to RAM (write pointer in LOAD, PC else)
//   imem_wr_data_o      RAM write data (zero when not writing)
//   imem_wr_en_o        RAM write strobe
//   imem_rd_data_i      RAM combinational read data
//   cpu_run_o           pipeline may run
//   load_busy_o         a load session is in progress
//   load_done_o         one-cycle pulse when a session completes
//   load_err_o          one-cycle pulse when a start request is rejected
//   load_words_o        words written in the current or last session
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        load_start_i,
    input  logic [31:0] load_base_addr_i,
    input  logic [10:0] load_count_i,
    input  logic        run_i,

    input  logic        load_valid_i,
    input  logic [31:0] load_data_i,
    output logic        load_ready_o,

    input  logic [31:0] fetch_addr_i,
    output logic [31:0] fetch_instr_o,
    output logic        fetch_stall_o,

    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wr_data_o,
    output logic        imem_wr_en_o,
    input  logic [31:0] imem_rd_data_i,

    output logic        cpu_run_o,
    output logic        load_busy_o,
    output logic        load_done_o,
    output logic        load_err_o,
    output logic [10:0] load_words_o
);

    // One extra bit so the pointer can step one past the last word of an
    // image that ends exactly at the top of memory without wrapping.
    localparam int PTR_W = $clog2(DEPTH_WORDS) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [10:0]      rem_q,   rem_d;
    logic [10:0]      words_q, words_d;
    logic             err_q,   err_d;

    // -------------------------------------------------------------------------
    // Start request range check. The end word is computed on the full 30-bit
    // word index so a huge base cannot alias back into range.
    // -------------------------------------------------------------------------
    logic [32:0] end_word;
    logic        count_ok;
    logic        span_ok;
    logic        start_ok;

    assign end_word = {3'b000, load_base_addr_i[31:2]} + {22'd0, load_count_i};
    assign count_ok = (load_count_i != 11'd0) &&
                      ({21'd0, load_count_i} <= 32'(DEPTH_WORDS));
    assign span_ok  = (end_word <= 33'(DEPTH_WORDS));
    assign start_ok = count_ok && span_ok;

    // Byte-offset bits of the base address carry no information.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^load_base_addr_i[1:0];

    logic in_load;
    logic in_run;
    logic wr_fire;

    assign in_load = (state_q == ST_LOAD);
    assign in_run  = (state_q == ST_RUN);
    assign wr_fire = in_load && load_valid_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        words_d = words_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                // A start request has priority over run_i. A rejected start
                // leaves the state alone even if run_i is also asserted.
                if (load_start_i) begin
                    if (start_ok) begin
                        state_d = ST_LOAD;
                        ptr_d   = load_base_addr_i[PTR_W+1:2];
                        rem_d   = load_count_i;
                        words_d = 11'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if ((state_q == ST_IDLE) && run_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_LOAD: begin
                // rem_q is at least 1 on entry, so rem_q == 1 marks the last word.
                if (load_valid_i) begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    rem_d   = rem_q - 11'd1;
                    words_d = words_q + 11'd1;
                    if (rem_q == 11'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Everything except load_err_o is decoded from the current state
    // so that the RAM write and the fetch path have zero added latency.
    // -------------------------------------------------------------------------
    assign load_ready_o   = in_load;
    assign imem_wr_en_o   = wr_fire;
    assign imem_wr_data_o = wr_fire ? load_data_i : 32'd0;

    // The write pointer owns the address bus for the whole LOAD state, not
    // only on write beats, so the RAM never sees a stray fetch address there.
    assign imem_addr_o    = in_load ? {{(30-PTR_W){1'b0}}, ptr_q, 2'b00}
                                    : fetch_addr_i;

    assign cpu_run_o      = in_run;
    assign fetch_stall_o  = !in_run;
    assign fetch_instr_o  = in_run ? imem_rd_data_i : NOP_INSTR;

    assign load_busy_o    = in_load;
    assign load_done_o    = (state_q == ST_DONE);
    assign load_err_o     = err_q;
    assign load_words_o   = words_q;

endmodule
